// File: rtl/axi_external_master_port.sv
// Registered AXI3 master port toward the SDRAM fabric: address rebasing, fixed sideband fields, 2-entry skid
// buffers on all five channels and an outstanding-burst limit. Optional error capture: AXI_ERROR_CAPTURE_EN.

module axi_emp_skid #(
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_en,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready
);
  logic [DW-1:0] r_mem [2];
  logic          r_wptr, r_rptr, r_ready;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          w_push, w_pop;

  assign o_ready = r_ready;
  assign w_push  = i_valid && r_ready;
  assign o_valid = (r_cnt != 2'd0) && i_en;
  assign w_pop   = o_valid && i_ready;
  assign o_data  = r_mem[r_rptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 2'd1;
  end

  // ready is registered from the next occupancy, so it never depends combinationally on the sink
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != 2'd2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

module axi_external_master_port #(
  parameter logic [31:0] BASE_ADDR       = 32'h00040000,
  parameter logic [3:0]  AXI_ID          = 4'h0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_bus_awaddr,
  input  logic [3:0]  i_bus_awlen,
  input  logic        i_bus_awvalid,
  output logic        o_bus_awready,
  input  logic [31:0] i_bus_wdata,
  input  logic        i_bus_wlast,
  input  logic        i_bus_wvalid,
  output logic        o_bus_wready,
  output logic        o_bus_bvalid,
  input  logic        i_bus_bready,
  input  logic [31:0] i_bus_araddr,
  input  logic [3:0]  i_bus_arlen,
  input  logic        i_bus_arvalid,
  output logic        o_bus_arready,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_rvalid,
  input  logic        i_bus_rready,
  output logic [3:0]  o_axm_awid,
  output logic [31:0] o_axm_awaddr,
  output logic [3:0]  o_axm_awlen,
  output logic [2:0]  o_axm_awsize,
  output logic [1:0]  o_axm_awburst,
  output logic [1:0]  o_axm_awlock,
  output logic [3:0]  o_axm_awcache,
  output logic [2:0]  o_axm_awprot,
  output logic        o_axm_awvalid,
  input  logic        i_axm_awready,
  output logic [3:0]  o_axm_wid,
  output logic [31:0] o_axm_wdata,
  output logic [3:0]  o_axm_wstrb,
  output logic        o_axm_wlast,
  output logic        o_axm_wvalid,
  input  logic        i_axm_wready,
  input  logic [3:0]  i_axm_bid,
  input  logic [1:0]  i_axm_bresp,
  input  logic        i_axm_bvalid,
  output logic        o_axm_bready,
  output logic [3:0]  o_axm_arid,
  output logic [31:0] o_axm_araddr,
  output logic [3:0]  o_axm_arlen,
  output logic [2:0]  o_axm_arsize,
  output logic [1:0]  o_axm_arburst,
  output logic [1:0]  o_axm_arlock,
  output logic [3:0]  o_axm_arcache,
  output logic [2:0]  o_axm_arprot,
  output logic        o_axm_arvalid,
  input  logic        i_axm_arready,
  input  logic [3:0]  i_axm_rid,
  input  logic [31:0] i_axm_rdata,
  input  logic [1:0]  i_axm_rresp,
  input  logic        i_axm_rlast,
  input  logic        i_axm_rvalid,
  output logic        o_axm_rready,
  output logic        o_err_sticky,
  output logic [31:0] o_err_addr
);
  logic [35:0] w_aw_in, w_aw_out, w_ar_in, w_ar_out;
  logic [32:0] w_w_out;
  logic [0:0]  w_b_unused;
  logic        w_aw_en, w_ar_en, w_aw_hs, w_b_hs, w_ar_hs, w_r_last_hs;
  logic [3:0]  r_wr_cnt, r_rd_cnt;
  logic        w_unused;

  assign w_aw_in = {i_bus_awaddr + BASE_ADDR, i_bus_awlen};
  assign w_ar_in = {i_bus_araddr + BASE_ADDR, i_bus_arlen};
  assign {o_axm_awaddr, o_axm_awlen} = w_aw_out;
  assign {o_axm_araddr, o_axm_arlen} = w_ar_out;
  assign {o_axm_wdata, o_axm_wlast}  = w_w_out;

  assign o_axm_awid = AXI_ID;  assign o_axm_arid = AXI_ID;  assign o_axm_wid = AXI_ID;
  assign o_axm_awsize = 3'b010;  assign o_axm_awburst = 2'b01;  assign o_axm_awlock = 2'b00;
  assign o_axm_awcache = 4'b0011;  assign o_axm_awprot = 3'b000;
  assign o_axm_arsize = 3'b010;  assign o_axm_arburst = 2'b01;  assign o_axm_arlock = 2'b00;
  assign o_axm_arcache = 4'b0011;  assign o_axm_arprot = 3'b000;
  assign o_axm_wstrb = 4'hF;

  assign w_aw_en     = (r_wr_cnt != 4'(MAX_OUTSTANDING));
  assign w_ar_en     = (r_rd_cnt != 4'(MAX_OUTSTANDING));
  assign w_aw_hs     = o_axm_awvalid && i_axm_awready;
  assign w_b_hs      = i_axm_bvalid && o_axm_bready;
  assign w_ar_hs     = o_axm_arvalid && i_axm_arready;
  assign w_r_last_hs = i_axm_rvalid && o_axm_rready && i_axm_rlast;
  assign w_unused    = ^{i_axm_bid, i_axm_bresp, i_axm_rid, i_axm_rresp, w_b_unused};

  axi_emp_skid #(.DW(36)) u_aw (.i_clk(i_clk), .i_rst(i_reset), .i_data(w_aw_in), .i_valid(i_bus_awvalid),
    .o_ready(o_bus_awready), .i_en(w_aw_en), .o_data(w_aw_out), .o_valid(o_axm_awvalid), .i_ready(i_axm_awready));
  axi_emp_skid #(.DW(33)) u_w (.i_clk(i_clk), .i_rst(i_reset), .i_data({i_bus_wdata, i_bus_wlast}),
    .i_valid(i_bus_wvalid), .o_ready(o_bus_wready), .i_en(1'b1), .o_data(w_w_out), .o_valid(o_axm_wvalid),
    .i_ready(i_axm_wready));
  axi_emp_skid #(.DW(1)) u_b (.i_clk(i_clk), .i_rst(i_reset), .i_data(1'b0), .i_valid(i_axm_bvalid),
    .o_ready(o_axm_bready), .i_en(1'b1), .o_data(w_b_unused), .o_valid(o_bus_bvalid), .i_ready(i_bus_bready));
  axi_emp_skid #(.DW(36)) u_ar (.i_clk(i_clk), .i_rst(i_reset), .i_data(w_ar_in), .i_valid(i_bus_arvalid),
    .o_ready(o_bus_arready), .i_en(w_ar_en), .o_data(w_ar_out), .o_valid(o_axm_arvalid), .i_ready(i_axm_arready));
  axi_emp_skid #(.DW(32)) u_r (.i_clk(i_clk), .i_rst(i_reset), .i_data(i_axm_rdata), .i_valid(i_axm_rvalid),
    .o_ready(o_axm_rready), .i_en(1'b1), .o_data(o_bus_rdata), .o_valid(o_bus_rvalid), .i_ready(i_bus_rready));

  // simultaneous inc/dec holds; a stray response at zero saturates instead of wrapping
  function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc, input logic dec);
    if (inc && !dec) return c + 4'd1;
    if (dec && !inc && c != 4'd0) return c - 4'd1;
    return c;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_wr_cnt <= cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
      r_rd_cnt <= cnt_next(r_rd_cnt, w_ar_hs, w_r_last_hs);
    end
  end

`ifdef AXI_ERROR_CAPTURE_EN
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic [31:0]   r_wa_fifo [2**PW];
  logic [31:0]   r_ra_fifo [2**PW];
  logic [PW-1:0] r_wa_wp, r_wa_rp, r_ra_wp, r_ra_rp;
  logic          r_err_sticky;
  logic [31:0]   r_err_addr;
  logic          w_b_err, w_r_err;

  assign w_b_err      = w_b_hs && (i_axm_bresp != 2'b00);
  assign w_r_err      = i_axm_rvalid && o_axm_rready && (i_axm_rresp != 2'b00);
  assign o_err_sticky = r_err_sticky;
  assign o_err_addr   = r_err_addr;

  // the outstanding counters double as FIFO occupancy, so pops at zero are dropped
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wa_wp <= '0;  r_wa_rp <= '0;  r_ra_wp <= '0;  r_ra_rp <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      if (w_aw_hs) r_wa_wp <= r_wa_wp + PW'(1);
      if (w_ar_hs) r_ra_wp <= r_ra_wp + PW'(1);
      if (w_b_hs && r_wr_cnt != 4'd0)      r_wa_rp <= r_wa_rp + PW'(1);
      if (w_r_last_hs && r_rd_cnt != 4'd0) r_ra_rp <= r_ra_rp + PW'(1);
      if (!r_err_sticky && (w_b_err || w_r_err)) begin
        r_err_sticky <= 1'b1;
        r_err_addr   <= w_b_err ? r_wa_fifo[r_wa_rp] : r_ra_fifo[r_ra_rp];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_aw_hs) r_wa_fifo[r_wa_wp] <= o_axm_awaddr;
    if (w_ar_hs) r_ra_fifo[r_ra_wp] <= o_axm_araddr;
  end
`else
  assign o_err_sticky = 1'b0;
  assign o_err_addr   = '0;
`endif
endmodule

// File: tb/tb_axi_external_master_port.sv
// Directed bench for axi_external_master_port: address table plus write/read/backpressure/limit/error sequences.

module tb_axi_external_master_port;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] bus_awaddr, bus_wdata, bus_araddr, bus_rdata;
  logic [3:0]  bus_awlen, bus_arlen;
  logic bus_awvalid, bus_awready, bus_wlast, bus_wvalid, bus_wready, bus_bvalid, bus_bready;
  logic bus_arvalid, bus_arready, bus_rvalid, bus_rready;
  logic [3:0]  axm_awid, axm_awlen, axm_awcache, axm_wid, axm_wstrb, axm_bid, axm_arid, axm_arlen, axm_arcache, axm_rid;
  logic [31:0] axm_awaddr, axm_wdata, axm_araddr, axm_rdata, err_addr;
  logic [2:0]  axm_awsize, axm_awprot, axm_arsize, axm_arprot;
  logic [1:0]  axm_awburst, axm_awlock, axm_arburst, axm_arlock, axm_bresp, axm_rresp;
  logic axm_awvalid, axm_awready, axm_wlast, axm_wvalid, axm_wready, axm_bvalid, axm_bready;
  logic axm_arvalid, axm_arready, axm_rlast, axm_rvalid, axm_rready, err_sticky;

  axi_external_master_port #(.BASE_ADDR(32'h00040000), .AXI_ID(4'h0), .MAX_OUTSTANDING(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_bus_awaddr(bus_awaddr), .i_bus_awlen(bus_awlen), .i_bus_awvalid(bus_awvalid), .o_bus_awready(bus_awready),
    .i_bus_wdata(bus_wdata), .i_bus_wlast(bus_wlast), .i_bus_wvalid(bus_wvalid), .o_bus_wready(bus_wready),
    .o_bus_bvalid(bus_bvalid), .i_bus_bready(bus_bready),
    .i_bus_araddr(bus_araddr), .i_bus_arlen(bus_arlen), .i_bus_arvalid(bus_arvalid), .o_bus_arready(bus_arready),
    .o_bus_rdata(bus_rdata), .o_bus_rvalid(bus_rvalid), .i_bus_rready(bus_rready),
    .o_axm_awid(axm_awid), .o_axm_awaddr(axm_awaddr), .o_axm_awlen(axm_awlen), .o_axm_awsize(axm_awsize),
    .o_axm_awburst(axm_awburst), .o_axm_awlock(axm_awlock), .o_axm_awcache(axm_awcache), .o_axm_awprot(axm_awprot),
    .o_axm_awvalid(axm_awvalid), .i_axm_awready(axm_awready),
    .o_axm_wid(axm_wid), .o_axm_wdata(axm_wdata), .o_axm_wstrb(axm_wstrb), .o_axm_wlast(axm_wlast),
    .o_axm_wvalid(axm_wvalid), .i_axm_wready(axm_wready),
    .i_axm_bid(axm_bid), .i_axm_bresp(axm_bresp), .i_axm_bvalid(axm_bvalid), .o_axm_bready(axm_bready),
    .o_axm_arid(axm_arid), .o_axm_araddr(axm_araddr), .o_axm_arlen(axm_arlen), .o_axm_arsize(axm_arsize),
    .o_axm_arburst(axm_arburst), .o_axm_arlock(axm_arlock), .o_axm_arcache(axm_arcache), .o_axm_arprot(axm_arprot),
    .o_axm_arvalid(axm_arvalid), .i_axm_arready(axm_arready),
    .i_axm_rid(axm_rid), .i_axm_rdata(axm_rdata), .i_axm_rresp(axm_rresp), .i_axm_rlast(axm_rlast),
    .i_axm_rvalid(axm_rvalid), .o_axm_rready(axm_rready),
    .o_err_sticky(err_sticky), .o_err_addr(err_addr));

`ifdef AXI_ERROR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [17:0] FIXED = {4'h0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000};

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vt[6];

  int checks = 0, failures = 0;
  int k, rn, hs, comb_viol;
  logic tog, prev_wready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    #1;
    chk("rst_valids", 64'({axm_awvalid, axm_wvalid, axm_arvalid, bus_bvalid, bus_rvalid}), 64'd0);
    chk("rst_readies", 64'({bus_awready, bus_wready, bus_arready, axm_bready, axm_rready}), 64'd0);
    chk("rst_err", 64'({err_sticky, err_addr}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", 64'({bus_awready, bus_wready, bus_arready, axm_bready, axm_rready}), 64'h1F);
    chk("post_rst_valids", 64'({axm_awvalid, axm_wvalid, axm_arvalid, bus_bvalid, bus_rvalid}), 64'd0);
  endtask

  task automatic issue_addr(input logic rd, input logic [31:0] a, input logic [3:0] l);
    if (rd) begin bus_araddr = a; bus_arlen = l; bus_arvalid = 1'b1; end
    else    begin bus_awaddr = a; bus_awlen = l; bus_awvalid = 1'b1; end
    @(negedge clk);
    bus_arvalid = 1'b0; bus_awvalid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    axm_bvalid = 1'b1; axm_bresp = resp;
    @(negedge clk);
    axm_bvalid = 1'b0; axm_bresp = 2'b00;
  endtask

  task automatic send_r(input logic [31:0] d, input logic last);
    axm_rvalid = 1'b1; axm_rdata = d; axm_rlast = last;
    @(negedge clk);
    axm_rvalid = 1'b0; axm_rlast = 1'b0;
  endtask

  // drives n single-beat requests on the bus side and counts handshakes on the master side
  task automatic burst_issue(input logic rd, input int n, input int window, output int nhs);
    int sent = 0;
    nhs = 0;
    for (int c = 0; c < window; c++) begin
      if (rd) begin
        bus_arvalid = (sent < n); bus_araddr = 32'(sent) * 32'h10; bus_arlen = 4'd0;
        if (bus_arvalid && bus_arready) sent++;
        if (axm_arvalid && axm_arready) nhs++;
      end else begin
        bus_awvalid = (sent < n); bus_awaddr = 32'(sent) * 32'h10; bus_awlen = 4'd0;
        if (bus_awvalid && bus_awready) sent++;
        if (axm_awvalid && axm_awready) nhs++;
      end
      @(negedge clk);
    end
    bus_arvalid = 1'b0; bus_awvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 32'h00000100, 4'd0,  32'h00040100};
    vt[1] = '{1'b1, 32'h00000000, 4'd7,  32'h00040000};
    vt[2] = '{1'b1, 32'hFFFFFFF0, 4'd0,  32'h0003FFF0};
    vt[3] = '{1'b0, 32'hFFFC0000, 4'd15, 32'h00000000};
    vt[4] = '{1'b0, 32'hFFFBFFFF, 4'd3,  32'hFFFFFFFF};
    vt[5] = '{1'b1, 32'h12345678, 4'd1,  32'h12385678};

    bus_awaddr = '0; bus_awlen = '0; bus_awvalid = 0; bus_wdata = '0; bus_wlast = 0; bus_wvalid = 0;
    bus_bready = 1; bus_araddr = '0; bus_arlen = '0; bus_arvalid = 0; bus_rready = 1;
    axm_awready = 1; axm_wready = 1; axm_arready = 1; axm_bid = '0; axm_bresp = '0; axm_bvalid = 0;
    axm_rid = '0; axm_rdata = '0; axm_rresp = '0; axm_rlast = 0; axm_rvalid = 0;
    reset_seq();

    for (int i = 0; i < 6; i++) begin
      chk("src_ready", 64'(vt[i].rd ? bus_arready : bus_awready), 64'd1);
      issue_addr(vt[i].rd, vt[i].addr, vt[i].len);
      if (vt[i].rd) begin
        chk("ar_valid", 64'(axm_arvalid), 64'd1);
        chk("ar_addr", 64'(axm_araddr), 64'(vt[i].exp_addr));
        chk("ar_len", 64'(axm_arlen), 64'(vt[i].len));
        chk("ar_fixed", 64'({axm_arid, axm_arsize, axm_arburst, axm_arlock, axm_arcache, axm_arprot}), 64'(FIXED));
        @(negedge clk);
        send_r(32'hC0DE0000 + 32'(i), 1'b1);
        chk("bus_rvalid", 64'(bus_rvalid), 64'd1);
        chk("bus_rdata", 64'(bus_rdata), 64'(32'hC0DE0000 + 32'(i)));
      end else begin
        chk("aw_valid", 64'(axm_awvalid), 64'd1);
        chk("aw_addr", 64'(axm_awaddr), 64'(vt[i].exp_addr));
        chk("aw_len", 64'(axm_awlen), 64'(vt[i].len));
        chk("aw_fixed", 64'({axm_awid, axm_awsize, axm_awburst, axm_awlock, axm_awcache, axm_awprot}), 64'(FIXED));
        @(negedge clk);
        send_b(2'b00);
        chk("bus_bvalid", 64'(bus_bvalid), 64'd1);
      end
      @(negedge clk);
    end

    // single write with data, one B back
    bus_wdata = 32'hDEADBEEF; bus_wlast = 1'b1; bus_wvalid = 1'b1;
    issue_addr(1'b0, 32'h100, 4'd0);
    bus_wvalid = 1'b0;
    chk("w1_awaddr", 64'(axm_awaddr), 64'h00040100);
    chk("w1_wvalid", 64'(axm_wvalid), 64'd1);
    chk("w1_wdata", 64'(axm_wdata), 64'hDEADBEEF);
    chk("w1_wlast", 64'(axm_wlast), 64'd1);
    chk("w1_wid_strb", 64'({axm_wid, axm_wstrb}), 64'h0F);
    @(negedge clk);
    send_b(2'b00);
    chk("w1_bvalid", 64'(bus_bvalid), 64'd1);
    @(negedge clk);
    chk("w1_bvalid_once", 64'(bus_bvalid), 64'd0);

    // 8-beat read returned in order
    issue_addr(1'b1, 32'h0, 4'd7);
    chk("r8_arlen", 64'(axm_arlen), 64'd7);
    @(negedge clk);
    k = 0; rn = 0;
    fork
      begin
        for (int c = 0; c < 40 && rn < 8; c++) begin
          axm_rvalid = 1'b1; axm_rdata = 32'h1000 + 32'(rn); axm_rlast = (rn == 7);
          if (axm_rready) rn++;
          @(negedge clk);
        end
        axm_rvalid = 1'b0; axm_rlast = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && k < 8; c++) begin
          @(negedge clk);
          if (bus_rvalid) begin
            chk("r8_beat", 64'(bus_rdata), 64'(32'h1000 + 32'(k)));
            k++;
          end
        end
      end
    join
    chk("r8_count", 64'(k), 64'd8);

    // 16 W beats through a 1010 wready pattern
    k = 0; rn = 0; tog = 1'b1; comb_viol = 0;
    fork
      begin
        for (int c = 0; c < 80 && rn < 16; c++) begin
          bus_wvalid = 1'b1; bus_wdata = 32'hA0000000 + 32'(rn); bus_wlast = (rn == 15);
          if (bus_wready) rn++;
          @(negedge clk);
        end
        bus_wvalid = 1'b0; bus_wlast = 1'b0;
      end
      begin
        for (int c = 0; c < 80 && k < 16; c++) begin
          @(negedge clk);
          prev_wready = bus_wready;
          axm_wready = tog; tog = ~tog;
          #1;
          if (bus_wready !== prev_wready) comb_viol++;
          if (axm_wvalid && axm_wready) begin
            chk("bp_wdata", 64'(axm_wdata), 64'(32'hA0000000 + 32'(k)));
            chk("bp_wlast", 64'(axm_wlast), 64'(k == 15));
            k++;
          end
        end
      end
    join
    axm_wready = 1'b1;
    chk("bp_count", 64'(k), 64'd16);
    chk("bp_wready_comb", 64'(comb_viol), 64'd0);
    @(negedge clk); @(negedge clk);
    chk("bp_drained", 64'(axm_wvalid), 64'd0);

    // outstanding read limit, 5th issues one cycle after the first rlast
    burst_issue(1'b1, 5, 12, hs);
    chk("lim_ar_hs", 64'(hs), 64'd4);
    chk("lim_masked", 64'(axm_arvalid), 64'd0);
    axm_rvalid = 1'b1; axm_rdata = 32'h5; axm_rlast = 1'b1;
    @(negedge clk);
    axm_rvalid = 1'b0; axm_rlast = 1'b0;
    chk("lim_5th_valid", 64'(axm_arvalid), 64'd1);
    chk("lim_5th_addr", 64'(axm_araddr), 64'h00040040);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_r(32'h6, 1'b1);

    // stray B at zero must saturate, leaving the write limit at exactly 4
    send_b(2'b00);
    burst_issue(1'b0, 5, 12, hs);
    chk("sat_aw_hs", 64'(hs), 64'd4);
    chk("sat_masked", 64'(axm_awvalid), 64'd0);
    send_b(2'b00);
    chk("sat_5th_valid", 64'(axm_awvalid), 64'd1);
    for (int i = 0; i < 4; i++) send_b(2'b00);
    @(negedge clk); @(negedge clk);

    // error capture (zero outputs when the feature is compiled out)
    issue_addr(1'b0, 32'h200, 4'd0);
    @(negedge clk);
    send_b(2'b10);
    chk("err_sticky", 64'(err_sticky), 64'(ERR_EN));
    chk("err_addr", 64'(err_addr), ERR_EN ? 64'h00040200 : 64'd0);
    issue_addr(1'b0, 32'h300, 4'd0);
    @(negedge clk);
    send_b(2'b11);
    chk("err_addr_hold", 64'(err_addr), ERR_EN ? 64'h00040200 : 64'd0);

    // reset with a W beat stalled in the buffer
    axm_wready = 1'b0;
    bus_wvalid = 1'b1; bus_wdata = 32'h77; bus_wlast = 1'b0;
    @(negedge clk);
    bus_wvalid = 1'b0;
    @(negedge clk);
    chk("stall_wvalid", 64'(axm_wvalid), 64'd1);
    reset_seq();
    axm_wready = 1'b1;
    @(negedge clk);
    chk("flush_wvalid", 64'(axm_wvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
